// File: rtl/csr_sys_unit_pkg.sv
// Shared types and constants for the SYSTEM-instruction sequencer.
// Holds FSM states, CSR op encodings, trap causes and the exact SYSTEM encodings.
package sys_pkg;

   typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_COMMIT, S_TRAP, S_RET} state_e;

   typedef enum logic [1:0] {
      CSR_NONE = 2'b00,
      CSR_RW   = 2'b01,
      CSR_RS   = 2'b10,
      CSR_RC   = 2'b11
   } csr_op_e;

   typedef enum logic [1:0] {K_CSR, K_TRAP, K_RET, K_WFI} kind_e;

   localparam logic [3:0]  CAUSE_ILLEGAL    = 4'd2;
   localparam logic [3:0]  CAUSE_BREAKPOINT = 4'd3;
   localparam logic [3:0]  CAUSE_ECALL_M    = 4'd11;

   localparam logic [6:0]  OPC_SYSTEM   = 7'h73;
   localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;
   localparam logic [31:0] INSTR_WFI    = 32'h1050_0073;

   typedef struct packed {
      logic [3:0]  cause;
      logic [31:0] pc;
      logic [31:0] tval;
      logic        is_irq;
   } trap_t;

   // Address space 0xC00-0xFFF is read-only in the CSR map.
   function automatic logic csr_read_only(input logic [11:0] addr);
      return addr[11:10] == 2'b11;
   endfunction

endpackage

// File: rtl/csr_sys_unit_if.sv
// Pipeline-side handshake: SYSTEM request in, rd writeback and PC redirect out.
interface csr_sys_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_instr;
   logic [31:0] req_pc;
   logic [31:0] req_rs1_val;
   logic        rsp_valid;
   logic        rsp_rd_we;
   logic [4:0]  rsp_rd_addr;
   logic [31:0] rsp_rd_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      output req_valid, req_instr, req_pc, req_rs1_val,
      input  req_ready, rsp_valid, rsp_rd_we, rsp_rd_addr, rsp_rd_data,
             redirect_valid, redirect_pc
   );

   modport slave (
      input  req_valid, req_instr, req_pc, req_rs1_val,
      output req_ready, rsp_valid, rsp_rd_we, rsp_rd_addr, rsp_rd_data,
             redirect_valid, redirect_pc
   );
endinterface

// File: rtl/csr_sys_unit_decode.sv
// Combinational SYSTEM decode: classifies the instruction and precomputes the
// CSR op, write data/enable, rd and the trap payload used if it faults.
module sys_decode
   import sys_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic [31:0] rs1_val,
   output kind_e       kind,
   output csr_op_e     op,
   output logic        we,
   output logic [31:0] wdata,
   output logic [4:0]  rd,
   output logic [3:0]  cause,
   output logic [31:0] tval
);

   logic [2:0] funct3;
   logic [4:0] rs1_fld;

   assign funct3  = instr[14:12];
   assign rs1_fld = instr[19:15];

   // Illegal-instruction payload is the default so a CSR access that faults
   // later already carries the right cause and tval.
   always_comb begin
      kind  = K_TRAP;
      op    = CSR_NONE;
      we    = 1'b0;
      wdata = '0;
      rd    = '0;
      cause = CAUSE_ILLEGAL;
      tval  = instr;
      if (instr[6:0] == OPC_SYSTEM) begin
         if (funct3[1:0] != 2'b00) begin
            kind  = K_CSR;
            op    = csr_op_e'(funct3[1:0]);
            wdata = funct3[2] ? {27'd0, rs1_fld} : rs1_val;
            we    = (funct3[1:0] == 2'b01) || (rs1_fld != 5'd0);
            rd    = instr[11:7];
         end else if (funct3 == 3'b000) begin
            case (instr)
               INSTR_ECALL:  begin cause = CAUSE_ECALL_M;    tval = '0; end
               INSTR_EBREAK: begin cause = CAUSE_BREAKPOINT; tval = pc; end
               INSTR_MRET:   kind = K_RET;
               INSTR_WFI:    kind = K_WFI;
               default:      ;
            endcase
         end
      end
   end

endmodule

// File: rtl/csr_sys_unit.sv
// SYSTEM-instruction sequencer: runs CSR accesses, ECALL/EBREAK/MRET/WFI and
// folds external exceptions and interrupts into single-cycle trap events.
module csr_sys_unit
   import sys_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   csr_sys_unit_if.slave bus,
   input  logic          exc_valid,
   input  logic [3:0]    exc_cause,
   input  logic [31:0]   exc_pc,
   input  logic [31:0]   exc_tval,
   input  logic          irq_pending,
   input  logic [3:0]    irq_cause,
   input  logic [31:0]   irq_pc,
   output logic [11:0]   csr_addr,
   output logic [31:0]   csr_wdata,
   output logic [1:0]    csr_op,
   output logic          csr_we,
   input  logic [31:0]   csr_rdata,
   input  logic          csr_illegal,
   output logic          trap_taken,
   output logic [31:0]   trap_pc,
   output logic [3:0]    trap_cause,
   output logic [31:0]   trap_value,
   output logic          is_interrupt,
   output logic          mret,
   input  logic [31:0]   mtvec_base,
   input  logic [31:0]   mepc_out
);

   state_e      state, state_nx;
   kind_e       dec_kind;
   csr_op_e     dec_op, r_op;
   logic        dec_we, r_we;
   logic [31:0] dec_wdata, r_wdata, dec_tval, r_rdata;
   logic [4:0]  dec_rd, r_rd;
   logic [3:0]  dec_cause;
   logic [11:0] r_addr;
   trap_t       r_trap;
   logic        ready, accept, acc_illegal;

   sys_decode u_decode (
      .instr   (bus.req_instr),
      .pc      (bus.req_pc),
      .rs1_val (bus.req_rs1_val),
      .kind    (dec_kind),
      .op      (dec_op),
      .we      (dec_we),
      .wdata   (dec_wdata),
      .rd      (dec_rd),
      .cause   (dec_cause),
      .tval    (dec_tval)
   );

   // Gated by rst_n so the handshake reads 0 while reset is held.
   assign ready         = rst_n && (state == S_IDLE) && !exc_valid && !irq_pending;
   assign accept        = ready && bus.req_valid;
   assign bus.req_ready = ready;
   assign acc_illegal   = csr_illegal || (r_we && csr_read_only(r_addr));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (exc_valid || irq_pending) state_nx = S_TRAP;
            else if (accept) begin
               case (dec_kind)
                  K_CSR:   state_nx = S_ACCESS;
                  K_RET:   state_nx = S_RET;
                  K_WFI:   state_nx = S_COMMIT;
                  default: state_nx = S_TRAP;
               endcase
            end
         end
         S_ACCESS: state_nx = acc_illegal ? S_TRAP : S_COMMIT;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op    <= CSR_NONE;
         r_we    <= 1'b0;
         r_wdata <= '0;
         r_rd    <= '0;
         r_addr  <= '0;
         r_rdata <= '0;
         r_trap  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (exc_valid)
                  r_trap <= '{cause: exc_cause, pc: exc_pc, tval: exc_tval, is_irq: 1'b0};
               else if (irq_pending)
                  r_trap <= '{cause: irq_cause, pc: irq_pc, tval: 32'd0, is_irq: 1'b1};
               else if (accept) begin
                  r_op    <= dec_op;
                  r_we    <= dec_we;
                  r_wdata <= dec_wdata;
                  r_rd    <= dec_rd;
                  r_addr  <= (dec_kind == K_CSR) ? bus.req_instr[31:20] : 12'd0;
                  r_rdata <= '0;
                  r_trap  <= '{cause: dec_cause, pc: bus.req_pc, tval: dec_tval, is_irq: 1'b0};
               end
            end
            S_ACCESS: r_rdata <= csr_rdata;
            default:  ;
         endcase
      end
   end

   // Every strobe lives in exactly one state, which keeps them exclusive.
   always_comb begin
      bus.rsp_valid      = 1'b0;
      bus.rsp_rd_we      = 1'b0;
      bus.rsp_rd_addr    = '0;
      bus.rsp_rd_data    = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      csr_addr           = '0;
      csr_wdata          = '0;
      csr_op             = CSR_NONE;
      csr_we             = 1'b0;
      trap_taken         = 1'b0;
      trap_pc            = '0;
      trap_cause         = '0;
      trap_value         = '0;
      is_interrupt       = 1'b0;
      mret               = 1'b0;
      case (state)
         S_ACCESS: csr_addr = r_addr;
         S_COMMIT: begin
            csr_addr        = r_addr;
            csr_wdata       = r_wdata;
            csr_op          = r_op;
            csr_we          = r_we;
            bus.rsp_valid   = 1'b1;
            bus.rsp_rd_we   = (r_rd != 5'd0);
            bus.rsp_rd_addr = r_rd;
            bus.rsp_rd_data = r_rdata;
         end
         S_TRAP: begin
            trap_taken         = 1'b1;
            trap_pc            = r_trap.pc;
            trap_cause         = r_trap.cause;
            trap_value         = r_trap.tval;
            is_interrupt       = r_trap.is_irq;
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = mtvec_base;
         end
         S_RET: begin
            mret               = 1'b1;
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = mepc_out;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_csr_sys_unit.sv
// Scoreboard bench for csr_sys_unit: directed cases plus randomized SYSTEM
// traffic checked against a behavioural model of the CSR/trap rules.
module tb_csr_sys_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   csr_sys_unit_if bus();

   logic        exc_valid = 1'b0, irq_pending = 1'b0;
   logic [3:0]  exc_cause = '0, irq_cause = '0;
   logic [31:0] exc_pc = '0, exc_tval = '0, irq_pc = '0;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata, csr_rdata;
   logic [1:0]  csr_op;
   logic        csr_we, csr_illegal;
   logic        trap_taken, is_interrupt, mret;
   logic [31:0] trap_pc, trap_value;
   logic [3:0]  trap_cause;
   logic [31:0] mtvec_base = 32'h8000_0400;
   logic [31:0] mepc_out   = 32'h8000_0104;

   csr_sys_unit dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
      .irq_pending(irq_pending), .irq_cause(irq_cause), .irq_pc(irq_pc),
      .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_op(csr_op), .csr_we(csr_we),
      .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
      .trap_taken(trap_taken), .trap_pc(trap_pc), .trap_cause(trap_cause),
      .trap_value(trap_value), .is_interrupt(is_interrupt), .mret(mret),
      .mtvec_base(mtvec_base), .mepc_out(mepc_out)
   );

   // Small CSR file behind the interface; ref_val is the model's own copy.
   logic [11:0] csr_list [6] = '{12'h340, 12'h301, 12'h305, 12'h341, 12'hF14, 12'hC00};
   logic [31:0] env_val  [6] = '{32'h11, 32'h4014_1101, 32'h0, 32'h0, 32'h0, 32'h1234};
   logic [31:0] ref_val  [6] = '{32'h11, 32'h4014_1101, 32'h0, 32'h0, 32'h0, 32'h1234};

   always_comb begin
      csr_rdata   = '0;
      csr_illegal = 1'b1;
      for (int i = 0; i < 6; i++)
         if (csr_addr == csr_list[i]) begin
            csr_rdata   = env_val[i];
            csr_illegal = 1'b0;
         end
   end

   always @(posedge clk)
      if (csr_we)
         for (int i = 0; i < 6; i++)
            if (csr_addr == csr_list[i])
               case (csr_op)
                  2'b01:   env_val[i] <= csr_wdata;
                  2'b10:   env_val[i] <= env_val[i] | csr_wdata;
                  2'b11:   env_val[i] <= env_val[i] & ~csr_wdata;
                  default: ;
               endcase

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      int          kind;   // 0 rsp, 1 trap, 2 mret
      logic        csr_we;
      logic [1:0]  op;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic        rd_we;
      logic [4:0]  rd;
      logic [31:0] rdata;
      logic [3:0]  cause;
      logic [31:0] tpc;
      logic [31:0] tval;
      logic        irq;
      logic [31:0] rpc;
   } ev_t;

   ev_t exp_q[$];
   int n_chk = 0, n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic int idx_of(input logic [11:0] a);
      for (int i = 0; i < 6; i++) if (csr_list[i] == a) return i;
      return -1;
   endfunction

   function automatic logic [31:0] mk_csr(input logic [11:0] a, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
      return {a, rs1, f3, rd, 7'h73};
   endfunction

   function automatic ev_t mk_trap(input int at, input logic [3:0] cause,
                                   input logic [31:0] pc, input logic [31:0] tval, input logic irq);
      ev_t e;
      e = '{default: 0};
      e.cyc = at; e.kind = 1; e.cause = cause; e.tpc = pc; e.tval = tval;
      e.irq = irq; e.rpc = mtvec_base;
      return e;
   endfunction

   // Reference model: what the instruction accepted in cycle acc must produce.
   task automatic model_issue(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [31:0] rs1v, input int acc);
      ev_t e;
      logic [2:0]  f3;
      logic [4:0]  zimm;
      logic [11:0] a;
      logic        wr;
      logic [31:0] src, old;
      int          i;
      e = '{default: 0};
      f3 = instr[14:12]; zimm = instr[19:15]; a = instr[31:20];
      if (instr[6:0] == 7'h73 && f3 != 3'd0 && f3 != 3'd4) begin
         wr  = (f3 == 3'd1 || f3 == 3'd5) || (zimm != 5'd0);
         src = (f3 >= 3'd5) ? {27'd0, zimm} : rs1v;
         i   = idx_of(a);
         if (i < 0 || (wr && a >= 12'hC00)) e = mk_trap(acc + 2, 4'd2, pc, instr, 1'b0);
         else begin
            old = ref_val[i];
            e.cyc = acc + 2; e.kind = 0; e.csr_we = wr; e.op = f3[1:0]; e.addr = a;
            e.wdata = src; e.rd_we = (instr[11:7] != 5'd0); e.rd = instr[11:7]; e.rdata = old;
            if (wr) begin
               if (f3 == 3'd1 || f3 == 3'd5)      ref_val[i] = src;
               else if (f3 == 3'd2 || f3 == 3'd6) ref_val[i] = old | src;
               else                               ref_val[i] = old & ~src;
            end
         end
      end else if (instr == 32'h0000_0073) e = mk_trap(acc + 1, 4'd11, pc, 32'd0, 1'b0);
      else if (instr == 32'h0010_0073)     e = mk_trap(acc + 1, 4'd3, pc, pc, 1'b0);
      else if (instr == 32'h3020_0073) begin
         e.cyc = acc + 1; e.kind = 2; e.rpc = mepc_out;
      end else if (instr == 32'h1050_0073) begin
         e.cyc = acc + 1; e.kind = 0;
      end else e = mk_trap(acc + 1, 4'd2, pc, instr, 1'b0);
      exp_q.push_back(e);
   endtask

   // Caller sits just after a negedge; returns one cycle after acceptance.
   task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rs1v, input bit expect_it);
      int n = 0;
      bus.req_valid = 1'b1; bus.req_instr = instr; bus.req_pc = pc; bus.req_rs1_val = rs1v;
      #1;
      while (!bus.req_ready && n < 50) begin step(); n++; end
      if (!bus.req_ready) begin
         n_chk++; n_err++;
         $display("FAIL accept_timeout: req_ready stayed %b, required 1", bus.req_ready);
         bus.req_valid = 1'b0;
         return;
      end
      if (expect_it) model_issue(instr, pc, rs1v, cyc);
      step();
      bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin step(); n++; end
      if (exp_q.size() != 0) begin
         n_chk++; n_err++;
         $display("FAIL drain_timeout: %0d events outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      step();
   endtask

   task automatic raise_exc(input logic [3:0] c, input logic [31:0] pc, input logic [31:0] tv);
      exc_valid = 1'b1; exc_cause = c; exc_pc = pc; exc_tval = tv;
      #1;
      chk("exc_blocks_ready", 32'(bus.req_ready), 32'd0);
      exp_q.push_back(mk_trap(cyc + 1, c, pc, tv, 1'b0));
      step();
      exc_valid = 1'b0;
   endtask

   task automatic raise_irq(input logic [3:0] c, input logic [31:0] pc);
      irq_pending = 1'b1; irq_cause = c; irq_pc = pc;
      #1;
      chk("irq_blocks_ready", 32'(bus.req_ready), 32'd0);
      exp_q.push_back(mk_trap(cyc + 1, c, pc, 32'd0, 1'b1));
      step();
      irq_pending = 1'b0;
   endtask

   function automatic logic any_output();
      return |{bus.req_ready, bus.rsp_valid, bus.rsp_rd_we, bus.rsp_rd_addr, bus.rsp_rd_data,
               bus.redirect_valid, bus.redirect_pc, csr_addr, csr_wdata, csr_op, csr_we,
               trap_taken, trap_pc, trap_cause, trap_value, is_interrupt, mret};
   endfunction

   // Monitor: every strobe cycle must match the oldest expected event.
   always @(negedge clk) begin
      ev_t e;
      if (bus.rsp_valid || trap_taken || mret || csr_we || bus.redirect_valid) begin
         if (exp_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL unexpected_strobe: rsp=%b trap=%b mret=%b we=%b at cycle %0d, required none",
                     bus.rsp_valid, trap_taken, mret, csr_we, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("event_cycle", cyc, e.cyc);
            chk("strobe_exclusive", 32'($onehot0({trap_taken, mret, csr_we})), 32'd1);
            chk("strobe_set", 32'({bus.rsp_valid, trap_taken, mret, bus.redirect_valid}),
                (e.kind == 0) ? 32'h8 : (e.kind == 1) ? 32'h5 : 32'h3);
            if (e.kind == 0) begin
               chk("csr_we", 32'(csr_we), 32'(e.csr_we));
               if (e.csr_we) begin
                  chk("csr_op", 32'(csr_op), 32'(e.op));
                  chk("csr_addr", 32'(csr_addr), 32'(e.addr));
                  chk("csr_wdata", csr_wdata, e.wdata);
               end
               chk("rsp_rd_we", 32'(bus.rsp_rd_we), 32'(e.rd_we));
               if (e.rd_we) begin
                  chk("rsp_rd_addr", 32'(bus.rsp_rd_addr), 32'(e.rd));
                  chk("rsp_rd_data", bus.rsp_rd_data, e.rdata);
               end
            end else if (e.kind == 1) begin
               chk("trap_cause", 32'(trap_cause), 32'(e.cause));
               chk("trap_pc", trap_pc, e.tpc);
               chk("trap_value", trap_value, e.tval);
               chk("is_interrupt", 32'(is_interrupt), 32'(e.irq));
               chk("trap_redirect", bus.redirect_pc, e.rpc);
            end else
               chk("mret_redirect", bus.redirect_pc, e.rpc);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] r, instr, pc, rs1v;
      logic [2:0]  f3;
      logic [4:0]  rs1f, rd;
      int          a;
      bus.req_valid = 1'b0; bus.req_instr = '0; bus.req_pc = '0; bus.req_rs1_val = '0;
      step(); step();
      chk("reset_outputs_zero", 32'(any_output()), 32'd0);
      rst_n = 1'b1;
      step();

      // Directed cases
      issue(mk_csr(12'h340, 5'd6, 3'b001, 5'd5), 32'h8000_0000, 32'hDEAD_BEEF, 1'b1);
      drain();
      issue(mk_csr(12'h301, 5'd0, 3'b010, 5'd1), 32'h8000_0004, 32'h0, 1'b1);
      drain();
      issue(32'hF143_9073, 32'h8000_0008, 32'h5555_AAAA, 1'b1);
      drain();
      issue(32'h0000_0073, 32'h8000_0100, 32'h0, 1'b1);
      drain();
      issue(32'h3020_0073, 32'h8000_0200, 32'h0, 1'b1);
      drain();

      // Exception and request together: exception wins, request stays pending.
      bus.req_valid = 1'b1; bus.req_instr = mk_csr(12'h340, 5'd0, 3'b010, 5'd2);
      bus.req_pc = 32'h8000_0300; bus.req_rs1_val = 32'h0;
      raise_exc(4'd4, 32'h8000_0044, 32'h0000_BAD0);
      issue(mk_csr(12'h340, 5'd0, 3'b010, 5'd2), 32'h8000_0300, 32'h0, 1'b1);
      drain();
      raise_irq(4'd7, 32'h8000_0500);
      drain();

      // Interrupt arriving while busy waits for IDLE.
      issue(mk_csr(12'h305, 5'd3, 3'b110, 5'd4), 32'h8000_0600, 32'h0, 1'b1);
      chk("busy_ready", 32'(bus.req_ready), 32'd0);
      irq_pending = 1'b1; irq_cause = 4'd11; irq_pc = 32'h8000_0604;
      exp_q.push_back(mk_trap(cyc + 3, 4'd11, 32'h8000_0604, 32'd0, 1'b1));
      step(); step(); step();
      irq_pending = 1'b0;
      drain();

      // Randomized traffic
      for (int it = 0; it < 160; it++) begin
         mtvec_base = $urandom & 32'hFFFF_FFFC;
         mepc_out   = $urandom & 32'hFFFF_FFFC;
         pc   = $urandom & 32'hFFFF_FFFC;
         rs1v = $urandom;
         r    = $urandom;
         case ($urandom_range(0, 11))
            0, 1, 2, 3, 4: begin
               a = $urandom_range(0, 6);
               case ($urandom_range(0, 5))
                  0: f3 = 3'd1; 1: f3 = 3'd2; 2: f3 = 3'd3;
                  3: f3 = 3'd5; 4: f3 = 3'd6; default: f3 = 3'd7;
               endcase
               rs1f = ($urandom_range(0, 3) == 0) ? 5'd0 : r[4:0];
               rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : r[9:5];
               instr = mk_csr((a == 6) ? 12'h7C0 : csr_list[a], rs1f, f3, rd);
               issue(instr, pc, rs1v, 1'b1);
            end
            5: issue(32'h0000_0073, pc, rs1v, 1'b1);
            6: issue(32'h0010_0073, pc, rs1v, 1'b1);
            7: issue(32'h3020_0073, pc, rs1v, 1'b1);
            8: issue(32'h1050_0073, pc, rs1v, 1'b1);
            9: begin
               case ($urandom_range(0, 2))
                  0:       instr = {r[31:15], 3'b100, r[11:7], 7'h73};
                  1:       instr = 32'h0020_0073;
                  default: instr = {r[31:7], 7'h33};
               endcase
               issue(instr, pc, rs1v, 1'b1);
            end
            10: raise_exc(r[3:0], pc, rs1v);
            default: raise_irq(r[3:0], pc);
         endcase
         drain();
      end

      // Reset during ACCESS aborts the write and every strobe.
      issue(mk_csr(12'h340, 5'd9, 3'b001, 5'd8), 32'h8000_0700, 32'hFFFF_0000, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("reset_mid_access_outputs", 32'(any_output()), 32'd0);
      step(); step();
      rst_n = 1'b1;
      step();
      issue(mk_csr(12'h340, 5'd0, 3'b010, 5'd3), 32'h8000_0800, 32'h0, 1'b1);
      drain();

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/csr_sys_unit.md
# csr_sys_unit

SYSTEM-instruction sequencer for the RV32 core and the sole initiator on the CSR/trap interface. It executes CSRRW/RS/RC(I), ECALL, EBREAK, MRET and WFI handed over from execute, and arbitrates external exceptions and masked interrupts into single trap events. It drives CSR access, trap and MRET strobes, and returns rd writeback and PC-redirect results to the pipeline.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid / req_ready  in/out  1  SYSTEM-instruction handshake; transfer when both high
- req_instr  in  32  instruction word (opcode 0x73)
- req_pc  in  32  PC of req_instr
- req_rs1_val  in  32  rs1 register value
- exc_valid  in  1  exception from another unit; sampled only in IDLE
- exc_cause  in  4  exception cause code
- exc_pc  in  32  faulting PC
- exc_tval  in  32  faulting value
- irq_pending  in  1  level, already masked (mip & mie & mstatus.MIE)
- irq_cause  in  4  interrupt cause code
- irq_pc  in  32  PC of next unexecuted instruction
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rd_we  out  1  write rd
- rsp_rd_addr  out  5  rd index
- rsp_rd_data  out  32  old CSR value
- redirect_valid  out  1  one-cycle pulse; fetch restarts at redirect_pc
- redirect_pc  out  32  new PC
- csr_addr, csr_wdata, csr_op, csr_we  out  12/32/2/1  CSR access (op 00 none, 01 RW, 10 RS, 11 RC)
- csr_rdata, csr_illegal  in  32/1  combinational read result
- trap_taken, trap_pc, trap_cause, trap_value, is_interrupt  out  1/32/4/32/1  trap strobe plus payload
- mret  out  1  MRET strobe
- mtvec_base, mepc_out  in  32/32  trap vector and return PC

## Operation
- FSM states: IDLE, ACCESS, COMMIT, TRAP, RET.
- IDLE priority: exc_valid, then irq_pending, then req_valid. req_ready = IDLE & !exc_valid & !irq_pending.
- Exception: latch exc_* and go to TRAP with is_interrupt=0.
- Interrupt: latch irq_cause and irq_pc and go to TRAP with is_interrupt=1, trap_value=0.
- Accepted request: latch instr, pc and rs1_val, then decode:
  - funct3 001/010/011 -> RW/RS/RC with wdata = rs1_val.
  - funct3 101/110/111 -> same ops with wdata = zero-extended zimm (instr[19:15]).
  - Write enable: RW always writes. RS/RC write only when instr[19:15] != 0.
  - Exact encodings: 0x00000073 ECALL (cause 11, tval 0); 0x00100073 EBREAK (cause 3, tval = pc); 0x30200073 -> RET; 0x10500073 WFI completes as NOP (rsp_valid, rd_we=0).
  - Anything else, including funct3 100, is illegal instruction: cause 2, tval = instr.
- ACCESS: drive csr_addr and csr_op = NONE, and capture csr_rdata.
  - Illegal if csr_illegal, or if a write is enabled and csr_addr[11:10] == 2'b11. Illegal goes to TRAP (cause 2, tval = instr). Otherwise go to COMMIT.
- COMMIT: drive csr_addr, csr_wdata and csr_op; csr_we = write enable.
  - rsp_valid=1, rsp_rd_we = (rd != 0), rsp_rd_data = value captured in ACCESS. Then IDLE.
- TRAP: trap_taken=1 with latched payload (trap_pc = req_pc for instruction traps).
  - redirect_valid=1, redirect_pc = mtvec_base. Then IDLE.
- RET: mret=1, redirect_valid=1, redirect_pc = mepc_out. Then IDLE.
- trap_taken, mret and csr_we are mutually exclusive in every cycle.

## Timing
- Reset: state IDLE; every output 0 (csr_op NONE); latches cleared. Reset mid-operation aborts with no strobe emitted.
- Latencies, counting the accept cycle as cycle 0:
  - CSR op: rsp and csr_we in cycle 2.
  - ECALL, EBREAK, illegal encoding, MRET, WFI: strobe in cycle 1.
  - Illegal CSR access: trap in cycle 2.
  - Exception or interrupt: trap in the cycle after sampling.
- req_ready is low outside IDLE. exc/irq arriving while busy wait for IDLE; the exc source holds exc_valid until IDLE.
- Same-cycle exc_valid and req_valid in IDLE: exception wins and the request stays pending.
- All strobes are single-cycle.

## Structure
- sys_pkg holds: state enum, CSR op encodings, cause codes (2, 3, 11), SYSTEM encodings, and read-only address rule.
- One natural sub-module: sys_decode (combinational instr -> kind, op, wdata source, write enable, rd).

## Test plan
- CSRRW x5, 0x340, x6 with x6=0xDEADBEEF, mscratch=0x11 -> cycle 2: csr_we=1, op=01, wdata=0xDEADBEEF; rsp rd=5, data=0x11.
- CSRRS x1, misa, x0 -> csr_we never 1; rsp rd=1, data=0x40141101.
- 0xF1439073 (CSRRW x0, mhartid, x7) -> no csr_we; trap_taken cause 2, tval 0xF1439073, redirect_pc = mtvec_base.
- ECALL at pc 0x80000100 with mtvec 0x80000400 -> cycle 1: trap_taken, cause 11, trap_pc 0x80000100, redirect_pc 0x80000400.
- MRET with mepc 0x80000104 -> cycle 1: mret=1, redirect 0x80000104, no rsp, no trap.
- exc_valid (cause 4) together with req_valid -> trap cause 4 and req_ready=0. Then irq_pending (cause 7) -> trap with is_interrupt=1. Finally, rst_n asserted during ACCESS -> every output 0 and no csr_we.
